// File: rtl/bus_cycle_sequencer_if.sv
// Request, response and bus-side signals of the bus cycle sequencer.
// Request handshake: a request transfers on the rising clk edge where req_valid && req_ready.
interface bus_cycle_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_io;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic        mem_read;
   logic        mem_write;
   logic        io_read;
   logic        io_write;
   logic [19:0] addr_out;
   logic [7:0]  data_out;
   logic        bus_ready;
   logic [7:0]  bus_rdata;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_err;

   modport slave (
      input  req_valid, req_write, req_io, req_addr, req_wdata, bus_ready, bus_rdata,
      output req_ready, mem_read, mem_write, io_read, io_write, addr_out, data_out,
             resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_write, req_io, req_addr, req_wdata, bus_ready, bus_rdata,
      input  req_ready, mem_read, mem_write, io_read, io_write, addr_out, data_out,
             resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Turns single-beat requests into T1-T2-T3-(Tw)-T4 bus cycles with wait states,
// timeout abort and a one-cycle response pulse.
module bus_cycle_sequencer #(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   bus_cycle_sequencer_if.slave  bus,
   output logic [2:0]            dbg_state
);

   localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  cnt_inc;
   logic           write_q, write_d;
   logic [3:0]     strb_q, strb_d;      // {mem_read, mem_write, io_read, io_write}
   logic [19:0]    addr_q, addr_d;
   logic [7:0]     data_q, data_d;
   logic           resp_valid_q, resp_valid_d;
   logic [7:0]     resp_rdata_q, resp_rdata_d;
   logic           resp_err_q, resp_err_d;

   function automatic logic [3:0] strobe_sel(input logic wr, input logic io);
      if (io) strobe_sel = wr ? 4'b0001 : 4'b0010;
      else    strobe_sel = wr ? 4'b0100 : 4'b1000;
   endfunction

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      strb_d       = strb_q;
      addr_d       = addr_q;
      data_d       = data_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         S_IDLE, S_T4: begin
            strb_d  = 4'b0000;
            state_d = S_IDLE;
            if (bus.req_valid) begin
               state_d = S_T1;
               cnt_d   = '0;
               write_d = bus.req_write;
               strb_d  = strobe_sel(bus.req_write, bus.req_io);
               addr_d  = bus.req_io ? {4'h0, bus.req_addr[15:0]} : bus.req_addr;
               data_d  = bus.req_write ? bus.req_wdata : 8'h00;
            end
         end
         S_T1: state_d = S_T2;
         S_T2: state_d = S_T3;
         S_T3, S_TW: begin
            if (state_q == S_TW) cnt_d = cnt_inc;
            if (bus.bus_ready) begin
               state_d      = S_T4;
               strb_d       = 4'b0000;
               resp_valid_d = 1'b1;
               resp_rdata_d = write_q ? 8'h00 : bus.bus_rdata;
               resp_err_d   = 1'b0;
            end else if (state_q == S_TW && cnt_inc == CW'(WAIT_TIMEOUT)) begin
               // Ready has priority; only a still-stalled target is aborted.
               state_d      = S_T4;
               strb_d       = 4'b0000;
               resp_valid_d = 1'b1;
               resp_rdata_d = 8'h00;
               resp_err_d   = 1'b1;
            end else begin
               state_d = S_TW;
            end
         end
         default: begin
            state_d = S_IDLE;
            strb_d  = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         strb_q       <= 4'b0000;
         addr_q       <= 20'h00000;
         data_q       <= 8'h00;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 8'h00;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         strb_q       <= strb_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE) || (state_q == S_T4);
   assign bus.mem_read   = strb_q[3];
   assign bus.mem_write  = strb_q[2];
   assign bus.io_read    = strb_q[1];
   assign bus.io_write   = strb_q[0];
   assign bus.addr_out   = addr_q;
   assign bus.data_out   = data_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign dbg_state      = state_q;

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
- Upstream stage of the bus control logic: converts single-beat memory/IO requests from the execution unit into 8088-style T1-T2-T3-(Tw)-T4 bus cycles.
- Drives the mem_read/mem_write/io_read/io_write strobes plus address and write data consumed by the bus control logic.
- Samples bus_ready for wait-state insertion, aborts stalled cycles after a timeout, and returns read data or an error to the requester over a valid/ready handshake.

Parameters:
WAIT_TIMEOUT, 15, maximum Tw cycles before abort; legal range 1..255; wait counter width clog2(WAIT_TIMEOUT+1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset asserted)
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request this cycle
req_write  in  1  1 = write, 0 = read
req_io  in  1  1 = IO space, 0 = memory space
req_addr  in  20  request address
req_wdata  in  8  write data
mem_read  out  1  memory read strobe to bus control logic
mem_write  out  1  memory write strobe
io_read  out  1  IO read strobe
io_write  out  1  IO write strobe
addr_out  out  20  cycle address to bus control logic
data_out  out  8  cycle write data to bus control logic
bus_ready  in  1  target ready; low inserts wait states
bus_rdata  in  8  read data from target
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  8  read data; 0 for writes and on error
resp_err  out  1  1 = cycle aborted by timeout

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-low.
- Reset (rst=0, any state including mid-cycle): state=IDLE, all strobes 0, addr_out=0, data_out=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. In-flight transaction is dropped with no response.
- req_ready is a combinational decode of state: 1 in IDLE and T4, else 0. It is therefore 1 during and immediately after reset.
- Handshake: accept on the rising edge where req_valid && req_ready.
  - Latch write, io, addr and wdata; next state T1.
  - If req_io=1, addr_out[19:16] is forced to 0.
  - data_out = req_wdata for writes, 0 for reads.
- States:
  - IDLE: no strobes. Stays in IDLE without a request.
  - T1, T2: exactly one strobe asserted, selected by the latched type. T1 -> T2 -> T3 unconditionally.
  - T3: strobe held; bus_ready sampled. bus_ready=1 -> T4 and capture the response. bus_ready=0 -> Tw.
  - Tw: strobe held; wait counter increments each Tw cycle.
    - bus_ready=1 -> T4 with normal capture. Ready wins over a simultaneous timeout.
    - Else if counter reaches WAIT_TIMEOUT -> T4 with resp_err=1 and resp_rdata=0.
  - T4: all strobes 0; resp_valid=1 for exactly this cycle.
    - req_valid=1 accepts back-to-back and goes to T1; else -> IDLE.
- Wait counter is cleared on entry to T1.
- Response capture happens on the T3/Tw exit edge:
  - resp_rdata = bus_rdata for reads, 0 for writes.
  - resp_err = 0.
  - resp_rdata and resp_err hold until the next capture or reset.
- addr_out and data_out hold their latched values from T1 through T4.
- Latency with zero waits: accept on edge E0 puts the sequencer in T1 after E0; resp_valid is high in the cycle after E3. This gives 4 cycles per back-to-back transfer. Each Tw adds 1 cycle.
- At most one of the four strobes is 1 in any cycle. Strobes are 0 in IDLE and T4.
- req_* inputs are ignored outside accept edges.

Test Plan:
- Reset mid-Tw of a memory read (rst=0 for 1 cycle) -> strobes 0 immediately (async), state IDLE, no resp_valid, req_ready=1.
- Memory read at addr 0xABCDE, bus_ready=1, bus_rdata=0x5A -> mem_read high for 3 cycles (T1-T3); resp_valid pulses 4 cycles after accept with rdata=0x5A, err=0.
- IO write at addr 0xF03F8, data 0xC3, bus_ready low for 2 cycles in T3/Tw -> addr_out=0x003F8, io_write high for 5 cycles, data_out=0xC3; resp_valid with rdata=0x00, err=0.
- Memory write with bus_ready held 0, WAIT_TIMEOUT=15 -> exactly 15 Tw cycles, then T4 with resp_valid=1, resp_err=1, resp_rdata=0.
- bus_ready rises in the same cycle the timeout would fire -> normal completion, resp_err=0, rdata captured.
- Two back-to-back requests (read then write, req_valid held) -> second accepted in first's T4; strobes 0 for exactly one cycle between them; 8 cycles total for both.
